// File: rtl/ff_edge_pipe.sv
// ff_edge_pipe
//   Mixed-edge register pipeline. The input word IN_OP(a, b) passes through
//   DEPTH stages. Each stage captures on the rising or falling edge of clk,
//   as selected by EDGE_MASK. The output is OUT_OP(last stage, c). A valid bit
//   travels with each word. The block also has a global stall (en), a flush
//   that clears valid bits, and a counter of delivered words.
//
// Ports
//   clk       in   single clock; each stage uses one of its two edges
//   rst_n     in   asynchronous reset, active-low
//   a, b      in   [WIDTH] operands combined into the input word
//   in_valid  in   a/b carry a word this cycle
//   c         in   [WIDTH] output-side operand, combinational to q
//   en        in   stage advance enable; 0 holds every stage
//   flush     in   clears every valid bit; data still follows en
//   q         out  [WIDTH] OUT_OP(last stage data, c)
//   q_valid   out  last stage valid
//   out_cnt   out  [CNT_W] words delivered, counted on posedge, wraps
module ff_edge_pipe #(
   parameter int          WIDTH     = 8,
   parameter int          DEPTH     = 2,
   parameter logic [15:0] EDGE_MASK = 16'h1,
   parameter int          IN_OP     = 0,
   parameter int          OUT_OP    = 1,
   parameter int          CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] c,
   input  logic             en,
   input  logic             flush,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic [CNT_W-1:0] out_cnt
);

   logic [WIDTH-1:0] in_word;
   logic [WIDTH-1:0] stage_data  [DEPTH];
   logic             stage_valid [DEPTH];

   always_comb begin
      in_word = a;
      case (IN_OP)
         0:       in_word = a & b;
         1:       in_word = a | b;
         2:       in_word = a ^ b;
         default: in_word = a;
      endcase
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic [WIDTH-1:0] src_d;
      logic             src_v;
      logic [WIDTH-1:0] d_r;
      logic             v_r;
      logic [WIDTH-1:0] nxt_d;
      logic             nxt_v;

      if (i == 0) begin : g_src_in
         assign src_d = in_word;
         assign src_v = in_valid;
      end else begin : g_src_prev
         assign src_d = stage_data[i-1];
         assign src_v = stage_valid[i-1];
      end

      // flush only kills the valid bit; the data path keeps obeying en
      assign nxt_d = en ? src_d : d_r;
      assign nxt_v = flush ? 1'b0 : (en ? src_v : v_r);

      if (EDGE_MASK[i]) begin : g_neg
         always_ff @(negedge clk or negedge rst_n) begin
            if (!rst_n) begin
               d_r <= '0;
               v_r <= 1'b0;
            end else begin
               d_r <= nxt_d;
               v_r <= nxt_v;
            end
         end
      end else begin : g_pos
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               d_r <= '0;
               v_r <= 1'b0;
            end else begin
               d_r <= nxt_d;
               v_r <= nxt_v;
            end
         end
      end

      assign stage_data[i]  = d_r;
      assign stage_valid[i] = v_r;
   end

   always_comb begin
      q = stage_data[DEPTH-1];
      case (OUT_OP)
         0:       q = stage_data[DEPTH-1] & c;
         1:       q = stage_data[DEPTH-1] | c;
         2:       q = stage_data[DEPTH-1] ^ c;
         default: q = stage_data[DEPTH-1];
      endcase
   end

   assign q_valid = stage_valid[DEPTH-1];

   // A word delivered on a posedge is one that sits valid at q while en is high;
   // with en low the last stage holds and the same word must not count twice.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_cnt <= '0;
      end else if (q_valid && en) begin
         out_cnt <= out_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ff_edge_pipe.sv
module tb_ff_edge_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] a, b, c;
   logic       in_valid, en, flush;

   logic [7:0] q0, q1, q2;
   logic       qv0, qv1, qv2;
   logic [7:0] cnt0, cnt1;
   logic [1:0] cnt2;

   int n_chk  = 0;
   int n_pass = 0;

   // three configurations sharing the same stimulus
   localparam int          NDUT = 3;
   localparam int          P_DEPTH [NDUT] = '{2, 4, 3};
   localparam logic [15:0] P_MASK  [NDUT] = '{16'h1, 16'h0, 16'h5};
   localparam int          P_IN    [NDUT] = '{0, 2, 1};
   localparam int          P_OUT   [NDUT] = '{1, 0, 2};
   localparam int          P_CW    [NDUT] = '{8, 8, 2};

   ff_edge_pipe u_dut0 (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .c(c),
      .en(en), .flush(flush), .q(q0), .q_valid(qv0), .out_cnt(cnt0));

   ff_edge_pipe #(.WIDTH(8), .DEPTH(4), .EDGE_MASK(16'h0), .IN_OP(2), .OUT_OP(0), .CNT_W(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .c(c),
      .en(en), .flush(flush), .q(q1), .q_valid(qv1), .out_cnt(cnt1));

   ff_edge_pipe #(.WIDTH(8), .DEPTH(3), .EDGE_MASK(16'h5), .IN_OP(1), .OUT_OP(2), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .c(c),
      .en(en), .flush(flush), .q(q2), .q_valid(qv2), .out_cnt(cnt2));

   always #5 clk = ~clk;

   // reference model: per-configuration word/valid slots plus a delivery counter
   logic [7:0] md [NDUT][16];
   bit         mv [NDUT][16];
   int         mcnt [NDUT];

   function automatic logic [7:0] fop(input int op, input logic [7:0] x, input logic [7:0] y);
      case (op)
         0:       return x & y;
         1:       return x | y;
         2:       return x ^ y;
         default: return x;
      endcase
   endfunction

   task automatic model_reset();
      for (int d = 0; d < NDUT; d++) begin
         mcnt[d] = 0;
         for (int i = 0; i < 16; i++) begin
            md[d][i] = 8'h00;
            mv[d][i] = 1'b0;
         end
      end
   endtask

   // e = 0 for a rising edge, 1 for a falling edge
   task automatic model_edge(input int e);
      logic [7:0] sd;
      bit         sv;
      for (int d = 0; d < NDUT; d++) begin
         if (e == 0 && mv[d][P_DEPTH[d]-1] && en)
            mcnt[d] = (mcnt[d] + 1) % (1 << P_CW[d]);
         // walk from the output backwards so same-edge neighbours see old values
         for (int i = P_DEPTH[d]-1; i >= 0; i--) begin
            if (int'(P_MASK[d][i]) == e) begin
               sd = (i == 0) ? fop(P_IN[d], a, b) : md[d][i-1];
               sv = (i == 0) ? in_valid : mv[d][i-1];
               if (en) begin
                  md[d][i] = sd;
                  mv[d][i] = sv && !flush;
               end else if (flush) begin
                  mv[d][i] = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      chk({tag, " d0 q"},   {24'd0, q0},   {24'd0, fop(P_OUT[0], md[0][P_DEPTH[0]-1], c)});
      chk({tag, " d0 qv"},  {31'd0, qv0},  {31'd0, mv[0][P_DEPTH[0]-1]});
      chk({tag, " d0 cnt"}, {24'd0, cnt0}, mcnt[0]);
      chk({tag, " d1 q"},   {24'd0, q1},   {24'd0, fop(P_OUT[1], md[1][P_DEPTH[1]-1], c)});
      chk({tag, " d1 qv"},  {31'd0, qv1},  {31'd0, mv[1][P_DEPTH[1]-1]});
      chk({tag, " d1 cnt"}, {24'd0, cnt1}, mcnt[1]);
      chk({tag, " d2 q"},   {24'd0, q2},   {24'd0, fop(P_OUT[2], md[2][P_DEPTH[2]-1], c)});
      chk({tag, " d2 qv"},  {31'd0, qv2},  {31'd0, mv[2][P_DEPTH[2]-1]});
      chk({tag, " d2 cnt"}, {30'd0, cnt2}, mcnt[2]);
   endtask

   // one clock: model the posedge, apply new inputs, check, model the negedge, check
   task automatic cyc(input logic [7:0] na, input logic [7:0] nb, input logic [7:0] nc,
                      input logic niv, input logic nen, input logic nfl, input string tag);
      @(posedge clk);
      model_edge(0);
      #1;
      a = na; b = nb; c = nc; in_valid = niv; en = nen; flush = nfl;
      #2 check_all({tag, " hi"});
      @(negedge clk);
      model_edge(1);
      #2 check_all({tag, " lo"});
   endtask

   task automatic rand_cyc(input string tag);
      cyc(8'($urandom), 8'($urandom), 8'($urandom), ($urandom % 4) != 0,
          ($urandom % 6) != 0, ($urandom % 20) == 0, tag);
   endtask

   task automatic reset_pulse();
      #1 rst_n = 1'b0;
      model_reset();
      #1 check_all("rst async");
      chk("rst qv0", {31'd0, qv0}, 32'd0);
      chk("rst cnt0", {24'd0, cnt0}, 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      check_all("rst held");
      @(negedge clk);
      model_edge(1);
      #2 check_all("rst rel");
   endtask

   localparam logic [1:0] EXP6 [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

   initial begin
      rst_n = 1'b0;
      a = 8'h00; b = 8'h00; c = 8'h00;
      in_valid = 1'b0; en = 1'b1; flush = 1'b0;
      model_reset();
      #2 check_all("reset");
      c = 8'hA5;
      #1 check_all("reset c");
      @(negedge clk);
      #2 rst_n = 1'b1;

      // single word through the default configuration
      c = 8'h01;
      cyc(8'hF0, 8'h3C, 8'h01, 1'b1, 1'b1, 1'b0, "t1 launch");
      chk("t1 qv before", {31'd0, qv0}, 32'd0);
      cyc(8'h00, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0, "t1 out");
      chk("t1 q", {24'd0, q0}, 32'h31);
      chk("t1 qv", {31'd0, qv0}, 32'd1);
      chk("t1 cnt pre", {24'd0, cnt0}, 32'd0);
      cyc(8'h00, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0, "t1 after");
      chk("t1 qv gone", {31'd0, qv0}, 32'd0);
      chk("t1 cnt", {24'd0, cnt0}, 32'd1);
      for (int k = 0; k < 4; k++) cyc(8'h00, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0, "t1 drain");

      // ten back-to-back words
      for (int k = 0; k < 10; k++) cyc(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b0, "t2 stream");
      for (int k = 0; k < 6; k++) cyc(8'h00, 8'h00, 8'($urandom), 1'b0, 1'b1, 1'b0, "t2 drain");

      // stall with two words in flight
      cyc(8'h5A, 8'hC3, 8'h0F, 1'b1, 1'b1, 1'b0, "t3 w0");
      cyc(8'h96, 8'h69, 8'h0F, 1'b1, 1'b1, 1'b0, "t3 w1");
      for (int k = 0; k < 3; k++) cyc(8'h11, 8'h22, 8'h0F, 1'b1, 1'b0, 1'b0, "t3 stall");
      for (int k = 0; k < 6; k++) cyc(8'h00, 8'h00, 8'h0F, 1'b0, 1'b1, 1'b0, "t3 resume");

      // flush a full pipe while new words keep arriving
      for (int k = 0; k < 6; k++) cyc(8'($urandom), 8'($urandom), 8'h33, 1'b1, 1'b1, 1'b0, "t4 fill");
      cyc(8'($urandom), 8'($urandom), 8'h33, 1'b1, 1'b1, 1'b1, "t4 flush");
      for (int k = 0; k < 6; k++) cyc(8'($urandom), 8'($urandom), 8'h33, 1'b1, 1'b1, 1'b0, "t4 refill");

      // asynchronous reset between edges, then a fresh word
      reset_pulse();
      cyc(8'h81, 8'h7E, 8'h44, 1'b1, 1'b1, 1'b0, "t5 launch");
      for (int k = 0; k < 5; k++) cyc(8'h00, 8'h00, 8'h44, 1'b0, 1'b1, 1'b0, "t5 drain");

      // counter wrap on the two-bit configuration
      reset_pulse();
      for (int k = 0; k < 7; k++) begin
         cyc(8'($urandom), 8'($urandom), 8'h00, k < 5, 1'b1, 1'b0, "t6");
         if (k >= 2) chk("t6 cnt2", {30'd0, cnt2}, {30'd0, EXP6[k-2]});
      end

      // random traffic with occasional stalls, flushes and resets
      for (int k = 0; k < 400; k++) begin
         rand_cyc("rand");
         if (k % 97 == 96) reset_pulse();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
